// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 key decoder slice.
//   - ps2_state_e : prefix-decoder states
//   - PFX_*       : Scan Code Set 2 prefix bytes
//   - KEY_*       : modifier make codes
//   - EVT_*       : bit positions inside the 20-bit event word
//   - is_discard(): keyboard status/reply bytes that never become events
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE_E0,
    ST_PRE_F0,
    ST_PRE_E0F0,
    ST_SKIP
  } ps2_state_e;

  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_F0 = 8'hF0;
  localparam logic [7:0] PFX_E1 = 8'hE1;

  // Pause sends E1 followed by seven more bytes that carry no key meaning.
  localparam int SKIP_BYTES = 7;

  localparam logic [7:0] KEY_LSHIFT = 8'h12;
  localparam logic [7:0] KEY_RSHIFT = 8'h59;
  localparam logic [7:0] KEY_CAPS   = 8'h58;

  localparam int EVT_W         = 20;
  localparam int EVT_BRK       = 19;
  localparam int EVT_EXT       = 18;
  localparam int EVT_SHIFT     = 17;
  localparam int EVT_CAPS      = 16;
  localparam int EVT_ASCII_LSB = 8;
  localparam int EVT_CODE_LSB  = 0;

  // Self-test pass, ack, echo, errors and buffer overrun bytes.
  function automatic logic is_discard(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFE, 8'h00, 8'hFF: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: byte-receiver side and CPU read side of the decoder.
//   slave  modport : the decoder (consumes bytes / reads, produces events)
//   master modport : the receiver + reader environment
//   byte_in/byte_valid/rx_wait : receiver link
//   rd_en/rd_data/empty/full/count/overflow/ovf_clr : FWFT event FIFO
//   shift_held/caps_lock : live modifier state
interface ps2_key_decoder_if #(parameter int DEPTH = 16);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          rx_wait;
  logic          rd_en;
  logic [19:0]   rd_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic          ovf_clr;
  logic          shift_held;
  logic          caps_lock;

  modport master (
    output byte_in, byte_valid, rd_en, ovf_clr,
    input  rx_wait, rd_data, empty, full, count, overflow, shift_held, caps_lock
  );

  modport slave (
    input  byte_in, byte_valid, rd_en, ovf_clr,
    output rx_wait, rd_data, empty, full, count, overflow, shift_held, caps_lock
  );
endinterface

// File: rtl/ps2_ascii_lut.sv
// ps2_ascii_lut: combinational Scan Code Set 2 to ASCII lookup.
//   code  : make/break code byte
//   ext   : code came after an E0 prefix (never mapped)
//   shift : either shift key down
//   caps  : caps-lock toggle state (affects letters only)
//   ascii : mapped character, 00 when unmapped
module ps2_ascii_lut (
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii
);
  logic [7:0]  letter;
  logic [15:0] pair;  // {unshifted, shifted}

  always_comb begin
    letter = '0;
    pair   = '0;
    ascii  = '0;
    case (code)
      8'h1C: letter = 8'h61; 8'h32: letter = 8'h62; 8'h21: letter = 8'h63;
      8'h23: letter = 8'h64; 8'h24: letter = 8'h65; 8'h2B: letter = 8'h66;
      8'h34: letter = 8'h67; 8'h33: letter = 8'h68; 8'h43: letter = 8'h69;
      8'h3B: letter = 8'h6A; 8'h42: letter = 8'h6B; 8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D; 8'h31: letter = 8'h6E; 8'h44: letter = 8'h6F;
      8'h4D: letter = 8'h70; 8'h15: letter = 8'h71; 8'h2D: letter = 8'h72;
      8'h1B: letter = 8'h73; 8'h2C: letter = 8'h74; 8'h3C: letter = 8'h75;
      8'h2A: letter = 8'h76; 8'h1D: letter = 8'h77; 8'h22: letter = 8'h78;
      8'h35: letter = 8'h79; 8'h1A: letter = 8'h7A;
      default: ;
    endcase
    case (code)
      8'h16: pair = {8'h31, 8'h21}; 8'h1E: pair = {8'h32, 8'h40};
      8'h26: pair = {8'h33, 8'h23}; 8'h25: pair = {8'h34, 8'h24};
      8'h2E: pair = {8'h35, 8'h25}; 8'h36: pair = {8'h36, 8'h5E};
      8'h3D: pair = {8'h37, 8'h26}; 8'h3E: pair = {8'h38, 8'h2A};
      8'h46: pair = {8'h39, 8'h28}; 8'h45: pair = {8'h30, 8'h29};
      8'h0E: pair = {8'h60, 8'h7E}; 8'h4E: pair = {8'h2D, 8'h5F};
      8'h55: pair = {8'h3D, 8'h2B}; 8'h54: pair = {8'h5B, 8'h7B};
      8'h5B: pair = {8'h5D, 8'h7D}; 8'h5D: pair = {8'h5C, 8'h7C};
      8'h4C: pair = {8'h3B, 8'h3A}; 8'h52: pair = {8'h27, 8'h22};
      8'h41: pair = {8'h2C, 8'h3C}; 8'h49: pair = {8'h2E, 8'h3E};
      8'h4A: pair = {8'h2F, 8'h3F};
      default: ;
    endcase
    if (!ext) begin
      if (letter != 8'h00)
        ascii = (shift ^ caps) ? letter - 8'h20 : letter;
      else if (pair != 16'h0000)
        ascii = shift ? pair[7:0] : pair[15:8];
      else begin
        case (code)
          8'h29:   ascii = 8'h20;
          8'h5A:   ascii = 8'h0D;
          8'h66:   ascii = 8'h08;
          8'h0D:   ascii = 8'h09;
          8'h76:   ascii = 8'h1B;
          default: ascii = 8'h00;
        endcase
      end
    end
  end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: Scan Code Set 2 prefix decoder with modifier tracking and
// a first-word-fall-through event FIFO.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ps2_key_decoder_if.slave (receiver link + FIFO read port)
// Parameters: DEPTH (power of two, >= 2), TIMEOUT_CYCLES (prefix abandon time).
// Build option: define PS2_KEY_ASCII_EN to fill the ascii field via
// ps2_ascii_lut; otherwise the field is 00 and the lookup is not built.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic             clk,
  input logic             rst,
  ps2_key_decoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_e state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic bv_q, bv_d;
  logic shl_q, shl_d, shr_q, shr_d;
  logic caps_held_q, caps_held_d, caps_lock_q, caps_lock_d;

  logic accept;
  logic evt_vld, evt_brk, evt_ext;
  logic shift_now;
  logic [7:0] evt_ascii;
  logic [EVT_W-1:0] evt_data;

  logic [EVT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic ovf_q, ovf_d;
  logic full, empty, pop, push_ok, drop;

  // The receiver holds byte_valid high for an unknown time; only its rising
  // edge marks a new byte.
  assign accept = bus.byte_valid & ~bv_q;
  assign bv_d   = bus.byte_valid;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    evt_vld = 1'b0;
    evt_brk = 1'b0;
    evt_ext = 1'b0;
    tmr_d   = tmr_q;
    if (accept)
      tmr_d = '0;
    else if (tmr_q != TLIM)
      tmr_d = tmr_q + 1'b1;

    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.byte_in == PFX_E0)      state_d = ST_PRE_E0;
          else if (bus.byte_in == PFX_F0) state_d = ST_PRE_F0;
          else if (bus.byte_in == PFX_E1) begin
            state_d = ST_SKIP;
            skip_d  = '0;
          end
          else if (!is_discard(bus.byte_in)) evt_vld = 1'b1;
        end
        ST_PRE_E0: begin
          if (bus.byte_in == PFX_F0) state_d = ST_PRE_E0F0;
          else if (bus.byte_in != PFX_E0) begin
            evt_vld = 1'b1;
            evt_ext = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_PRE_F0: begin
          evt_vld = 1'b1;
          evt_brk = 1'b1;
          state_d = ST_IDLE;
        end
        ST_PRE_E0F0: begin
          evt_vld = 1'b1;
          evt_brk = 1'b1;
          evt_ext = 1'b1;
          state_d = ST_IDLE;
        end
        ST_SKIP: begin
          if (skip_q == 3'(SKIP_BYTES - 1)) state_d = ST_IDLE;
          else                              skip_d  = skip_q + 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && tmr_q == TLIM) begin
      // A lost byte would otherwise leave us stuck mid-prefix forever.
      state_d = ST_IDLE;
    end
  end

  // Modifiers update alongside the event so its flags reflect the new state.
  always_comb begin
    shl_d       = shl_q;
    shr_d       = shr_q;
    caps_held_d = caps_held_q;
    caps_lock_d = caps_lock_q;
    if (evt_vld && !evt_ext) begin
      case (bus.byte_in)
        KEY_LSHIFT: shl_d = ~evt_brk;
        KEY_RSHIFT: shr_d = ~evt_brk;
        KEY_CAPS: begin
          if (evt_brk) caps_held_d = 1'b0;
          else begin
            // Typematic repeats arrive as extra makes; toggle on the first only.
            if (!caps_held_q) caps_lock_d = ~caps_lock_q;
            caps_held_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign shift_now = shl_d | shr_d;

`ifdef PS2_KEY_ASCII_EN
  ps2_ascii_lut u_lut (
    .code  (bus.byte_in),
    .ext   (evt_ext),
    .shift (shift_now),
    .caps  (caps_lock_d),
    .ascii (evt_ascii)
  );
`else
  assign evt_ascii = '0;
`endif

  assign evt_data = {evt_brk, evt_ext, shift_now, caps_lock_d, evt_ascii, bus.byte_in};

  // FIFO: a pop frees the slot in the same cycle, so push+pop while full fits.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = bus.rd_en & ~empty;
  assign push_ok = evt_vld & (~full | pop);
  assign drop    = evt_vld & full & ~pop;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop);
    ovf_d    = drop | (ovf_q & ~bus.ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      skip_q      <= '0;
      tmr_q       <= '0;
      bv_q        <= 1'b0;
      shl_q       <= 1'b0;
      shr_q       <= 1'b0;
      caps_held_q <= 1'b0;
      caps_lock_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      tmr_q       <= tmr_d;
      bv_q        <= bv_d;
      shl_q       <= shl_d;
      shr_q       <= shr_d;
      caps_held_q <= caps_held_d;
      caps_lock_q <= caps_lock_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= evt_data;
  end

  // Gate the head with empty so stale storage never shows after reset.
  assign bus.rd_data    = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.empty      = empty;
  assign bus.full       = full;
  assign bus.count      = count_q;
  assign bus.overflow   = ovf_q;
  assign bus.rx_wait    = ~full;
  assign bus.shift_held = shl_q | shr_q;
  assign bus.caps_lock  = caps_lock_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;
  localparam int DEPTH = 16;
  localparam int TMO   = 40;
`ifdef PS2_KEY_ASCII_EN
  localparam bit ASC = 1'b1;
`else
  localparam bit ASC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps2_key_decoder_if #(.DEPTH(DEPTH)) bus ();
  ps2_key_decoder #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int nvec = 0, nmis = 0;

  // ---------------- reference model ----------------
  logic [19:0] q[$];
  bit m_ovf, m_shl, m_shr, m_ch, m_caps, m_ext, m_brk, m_prev_bv;
  int m_skip, cyc, last_acc;

  string LET = "abcdefghijklmnopqrstuvwxyz";
  logic [7:0] LETC [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
                            8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
                            8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0] LO [21] = '{8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,8'h30,
                          8'h60,8'h2D,8'h3D,8'h5B,8'h5D,8'h5C,8'h3B,8'h27,8'h2C,8'h2E,8'h2F};
  logic [7:0] HI [21] = '{8'h21,8'h40,8'h23,8'h24,8'h25,8'h5E,8'h26,8'h2A,8'h28,8'h29,
                          8'h7E,8'h5F,8'h2B,8'h7B,8'h7D,8'h7C,8'h3A,8'h22,8'h3C,8'h3E,8'h3F};
  logic [7:0] SYMC [21] = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45,
                            8'h0E,8'h4E,8'h55,8'h54,8'h5B,8'h5D,8'h4C,8'h52,8'h41,8'h49,8'h4A};
  logic [7:0] POOL [16] = '{8'h1C,8'h32,8'h16,8'h4A,8'h12,8'h59,8'h58,8'hF0,
                            8'hF0,8'hE0,8'hE0,8'hAA,8'h29,8'h5A,8'h0D,8'h75};

  function automatic logic [7:0] av(input logic [7:0] x);
    return ASC ? x : 8'h00;
  endfunction

  function automatic logic [7:0] mdl_ascii(input logic [7:0] c, input bit ext, input bit sh, input bit cp);
    if (!ASC || ext) return 8'h00;
    for (int i = 0; i < 26; i++)
      if (c == LETC[i]) return (sh ^ cp) ? LET[i] - 8'd32 : LET[i];
    for (int i = 0; i < 21; i++)
      if (c == SYMC[i]) return sh ? HI[i] : LO[i];
    case (c)
      8'h29: return 8'h20;
      8'h5A: return 8'h0D;
      8'h66: return 8'h08;
      8'h0D: return 8'h09;
      8'h76: return 8'h1B;
      default: return 8'h00;
    endcase
  endfunction

  task automatic mdl_decode(input logic [7:0] b, output bit ev, output logic [19:0] d);
    bit brk, ext;
    ev = 0; d = '0; brk = 0; ext = 0;
    if (m_skip > 0) begin m_skip--; return; end
    if (m_brk) begin ev = 1; brk = 1; ext = m_ext; end
    else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1;
      else if (b != 8'hE0) begin ev = 1; ext = 1; end
    end
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE1) m_skip = 7;
    else if (!(b inside {8'hAA,8'hFA,8'hEE,8'hFC,8'hFE,8'h00,8'hFF})) ev = 1;
    if (ev) begin
      m_ext = 0; m_brk = 0;
      if (!ext) begin
        if (b == 8'h12) m_shl = !brk;
        if (b == 8'h59) m_shr = !brk;
        if (b == 8'h58) begin
          if (brk) m_ch = 0;
          else begin if (!m_ch) m_caps = !m_caps; m_ch = 1; end
        end
      end
      d = {brk, ext, m_shl | m_shr, m_caps, mdl_ascii(b, ext, m_shl | m_shr, m_caps), b};
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("rd_data", 32'(bus.rd_data), (q.size() > 0) ? 32'(q[0]) : 32'h0);
    chk("count", 32'(bus.count), 32'(q.size()));
    chk("empty", 32'(bus.empty), 32'(q.size() == 0));
    chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
    chk("rx_wait", 32'(bus.rx_wait), 32'(q.size() != DEPTH));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("shift_held", 32'(bus.shift_held), 32'(m_shl | m_shr));
    chk("caps_lock", 32'(bus.caps_lock), 32'(m_caps));
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input bit bv, input logic [7:0] b, input bit rd, input bit clr);
    bit ev, drop;
    logic [19:0] d;
    bus.byte_valid = bv; bus.byte_in = b; bus.rd_en = rd; bus.ovf_clr = clr;
    ev = 0; drop = 0; d = '0;
    if (bv && !m_prev_bv) begin
      if ((m_ext || m_brk || m_skip > 0) && (cyc - last_acc > TMO)) begin
        m_ext = 0; m_brk = 0; m_skip = 0;
      end
      mdl_decode(b, ev, d);
      last_acc = cyc;
    end
    if (rd && q.size() > 0) void'(q.pop_front());
    if (ev) begin
      if (q.size() < DEPTH) q.push_back(d);
      else drop = 1;
    end
    m_ovf = drop | (m_ovf & !clr);
    m_prev_bv = bv;
    @(posedge clk); cyc++; #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] b);
    step(1, b, 0, 0);
    step(0, b, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    bus.byte_valid = 0; bus.byte_in = '0; bus.rd_en = 0; bus.ovf_clr = 0;
    repeat (2) begin @(posedge clk); cyc++; end
    #1;
    rst = 0;
    q.delete();
    m_ovf = 0; m_shl = 0; m_shr = 0; m_ch = 0; m_caps = 0;
    m_ext = 0; m_brk = 0; m_skip = 0; m_prev_bv = 0; last_acc = cyc;
    chk("rst_empty", 32'(bus.empty), 32'h1);
    chk("rst_full", 32'(bus.full), 32'h0);
    chk("rst_count", 32'(bus.count), 32'h0);
    chk("rst_rx_wait", 32'(bus.rx_wait), 32'h1);
    chk("rst_rd_data", 32'(bus.rd_data), 32'h0);
    chk("rst_ovf", 32'(bus.overflow), 32'h0);
    chk("rst_mods", 32'({bus.shift_held, bus.caps_lock}), 32'h0);
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 2 && !bus.empty; k++) step(0, 8'h00, 1, 0);
    chk("drained", 32'(bus.empty), 32'h1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0]  b [4];
    int          nb;
    int          nev;
    logic [19:0] last;
  } vec_t;
  vec_t tbl [13];

  function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, input int nb, nev, input logic [19:0] last);
    vec_t v;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.nb = nb; v.nev = nev; v.last = last;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [19:0] last;
    int n;
    cyc = 0;
    tbl[0]  = mk(8'h1C, 0, 0, 0, 1, 1, {4'b0000, av(8'h61), 8'h1C});
    tbl[1]  = mk(8'hF0, 8'h1C, 0, 0, 2, 1, {4'b1000, av(8'h61), 8'h1C});
    tbl[2]  = mk(8'hE0, 8'h75, 0, 0, 2, 1, {4'b0100, 8'h00, 8'h75});
    tbl[3]  = mk(8'hAA, 8'hFA, 0, 0, 2, 0, 20'h0);
    tbl[4]  = mk(8'hE0, 8'hF0, 8'h75, 0, 3, 1, {4'b1100, 8'h00, 8'h75});
    tbl[5]  = mk(8'h12, 8'h1C, 0, 0, 2, 2, {4'b0010, av(8'h41), 8'h1C});
    tbl[6]  = mk(8'hF0, 8'h1C, 0, 0, 2, 1, {4'b1010, av(8'h41), 8'h1C});
    tbl[7]  = mk(8'hF0, 8'h12, 0, 0, 2, 1, {4'b1000, 8'h00, 8'h12});
    tbl[8]  = mk(8'h29, 8'h0D, 8'h5A, 0, 3, 3, {4'b0000, av(8'h0D), 8'h5A});
    tbl[9]  = mk(8'hE0, 8'hE0, 8'h6B, 0, 3, 1, {4'b0100, 8'h00, 8'h6B});
    tbl[10] = mk(8'h58, 8'h58, 8'hF0, 8'h58, 4, 3, {4'b1001, 8'h00, 8'h58});
    tbl[11] = mk(8'h1C, 0, 0, 0, 1, 1, {4'b0001, av(8'h41), 8'h1C});
    tbl[12] = mk(8'h58, 8'hF0, 8'h58, 0, 3, 2, {4'b1000, 8'h00, 8'h58});

    do_reset();
    for (int i = 0; i < 13; i++) begin
      for (int j = 0; j < tbl[i].nb; j++) send(tbl[i].b[j]);
      chk($sformatf("tbl%0d_count", i), 32'(bus.count), 32'(tbl[i].nev));
      last = '0;
      for (int k = 0; k < DEPTH + 2 && !bus.empty; k++) begin
        last = bus.rd_data;
        step(0, 8'h00, 1, 0);
      end
      chk($sformatf("tbl%0d_last", i), 32'(last), 32'(tbl[i].last));
    end

    do_reset();
    for (int i = 0; i < DEPTH; i++) send(8'h1C);
    chk("fill_full", 32'(bus.full), 32'h1);
    chk("fill_rx_wait", 32'(bus.rx_wait), 32'h0);
    chk("fill_ovf0", 32'(bus.overflow), 32'h0);
    send(8'h1C);
    chk("drop_ovf", 32'(bus.overflow), 32'h1);
    chk("drop_count", 32'(bus.count), 32'(DEPTH));
    step(0, 8'h00, 0, 1);
    chk("ovf_clr", 32'(bus.overflow), 32'h0);
    step(1, 8'h32, 1, 0);
    chk("pushpop_count", 32'(bus.count), 32'(DEPTH));
    chk("pushpop_ovf", 32'(bus.overflow), 32'h0);
    step(0, 8'h32, 0, 0);
    step(1, 8'h32, 0, 1);
    chk("clr_vs_drop", 32'(bus.overflow), 32'h1);
    step(0, 8'h32, 0, 0);
    drain();

    do_reset();
    send(8'hF0);
    repeat (5) step(0, 8'h00, 0, 0);
    send(8'h1C);
    chk("short_gap", 32'(bus.rd_data), 32'({4'b1000, av(8'h61), 8'h1C}));
    drain();
    send(8'hF0);
    repeat (TMO + 5) step(0, 8'h00, 0, 0);
    send(8'h1C);
    chk("tmo_count", 32'(bus.count), 32'h1);
    chk("tmo_make", 32'(bus.rd_data), 32'({4'b0000, av(8'h61), 8'h1C}));
    drain();

    send(8'hE0);
    do_reset();
    send(8'h1C);
    chk("rst_prefix", 32'(bus.rd_data), 32'({4'b0000, av(8'h61), 8'h1C}));
    drain();
    send(8'hE1);
    foreach (POOL[i]) if (i < 7) send(POOL[i]);
    chk("pause_none", 32'(bus.count), 32'h0);
    send(8'h32);
    chk("pause_after", 32'(bus.rd_data), 32'({4'b0000, av(8'h62), 8'h32}));
    drain();

    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] b;
      bit rd;
      b  = ($urandom_range(0, 49) == 0) ? 8'hE1 : POOL[$urandom_range(0, 15)];
      rd = (i < 500) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 1);
      step($urandom_range(0, 2) != 0, b, rd, $urandom_range(0, 19) == 0);
    end
    n = 0;
    for (int k = 0; k < DEPTH + 2 && !bus.empty; k++) begin step(0, 8'h00, 1, 0); n++; end
    chk("rand_drained", 32'(bus.empty), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Consumes raw scan-code bytes from the PS/2 byte receiver and decodes Scan Code Set 2 prefixes (E0, F0, E1) into key events. Tracks the shift and caps-lock modifiers. Buffers events in a first-word-fall-through (FWFT) FIFO for the keyboard memory / CPU read port. It also drives the receiver's wait-for-data request, so bytes are only solicited while buffer space exists.

## Interface
- `DEPTH`, 16: FIFO entries; must be a power of two, minimum 2.
- `TIMEOUT_CYCLES`, 1000000: idle cycles after which a partial prefix sequence is abandoned (20 ms at 50 MHz).
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `byte_in`  in  8  scan-code byte from the receiver.
- `byte_valid`  in  1  receiver byte-complete flag. Only its rising edge is significant.
- `rx_wait`  out  1  request to the receiver; equals `!full`.
- `rd_en`  in  1  pop the head entry.
- `rd_data`  out  20  head entry: [19] break, [18] extended, [17] shift, [16] caps, [15:8] ascii, [7:0] code.
- `empty`  out  1  FIFO empty.
- `full`  out  1  FIFO full.
- `count`  out  $clog2(DEPTH)+1  occupancy.
- `overflow`  out  1  sticky: an event was dropped.
- `ovf_clr`  in  1  clears `overflow`.
- `shift_held`  out  1  left or right shift currently down.
- `caps_lock`  out  1  caps-lock toggle state.

## Operation
- Byte accept: a byte is accepted in a cycle where `byte_valid`=1 and the registered previous value was 0. `byte_in` is sampled in that cycle.
- States and transitions:
  - IDLE: E0 goes to PRE_E0. F0 goes to PRE_F0. E1 goes to SKIP. AA, FA, EE, FC, FE, 00 and FF are discarded and the block stays in IDLE. Any other byte emits a make event with ext=0.
  - PRE_E0: F0 goes to PRE_E0F0. E0 stays in PRE_E0. Any other byte emits a make event with ext=1 and returns to IDLE.
  - PRE_F0: any byte emits a break event with ext=0 and returns to IDLE.
  - PRE_E0F0: any byte emits a break event with ext=1 and returns to IDLE.
  - SKIP: discards the next 7 bytes (Pause sequence), then returns to IDLE. No event is emitted.
- Timeout: a counter clears on every accepted byte. In any non-IDLE state, reaching `TIMEOUT_CYCLES` forces IDLE.
- Modifiers (non-extended codes only), updated in the same cycle as the event:
  - 12 and 59 set or clear `shift_l` / `shift_r` on make/break.
  - A make of 58 toggles `caps_lock` only if `caps_held`=0, then sets `caps_held`. A break of 58 clears `caps_held`. Typematic repeat therefore does not re-toggle.
- Event flags carry the modifier state after the update. Modifier keys are enqueued like any other key.
- FIFO behaviour:
  - A push while full is dropped and `overflow` is set.
  - A push and a pop in the same cycle while full are both performed; `overflow` is not set.
  - `rd_en` while empty is ignored.
  - Pointers wrap modulo `DEPTH`.
  - If `ovf_clr` and a drop occur in the same cycle, `overflow` stays 1.
- Reset values: state IDLE, FIFO empty (`empty`=1, `full`=0, `count`=0), `rx_wait`=1, `overflow`=0, `shift_held`=0, `caps_lock`=0, `rd_data`=0. Reset mid-sequence discards the partial prefix and all queued events.

## Timing
- Accepted byte in cycle N: the event is written at the end of N. `empty` and `count` update in N+1.
- `rd_data` is FWFT: it is valid whenever `empty`=0. A pop in cycle N shows the next entry in N+1.
- `rx_wait` is combinational from `full`.
- Decoding and the modifier update complete in a single cycle. There is no back-pressure on `byte_valid`.

## Configuration
- `PS2_KEY_ASCII_EN` defined: the ascii field is filled by the lookup.
  - Letters: uppercase when shift XOR caps is 1.
  - Digits and punctuation: shifted when shift is 1.
  - Fixed codes: 29→20, 5A→0D, 66→08, 0D→09, 76→1B.
  - Extended and unmapped codes give 00.
- `PS2_KEY_ASCII_EN` undefined: the ascii field is constant 00 and the lookup is not instantiated.

## Structure
- Shared package `ps2_pkg`:
  - state enum.
  - prefix constants (E0, F0, E1) and the discard-code list.
  - modifier codes (12, 59, 58).
  - event field bit positions.
- Sub-module `ps2_ascii_lut`: combinational; inputs code, ext, shift, caps; output ascii[7:0]. It is instantiated only under `PS2_KEY_ASCII_EN`.

## Test plan
- Bytes 1C then F0 1C: two events, 0001C with ascii 61 and break=1 on the second; with the macro off, ascii=00.
- 12, 1C, F0 1C, F0 12: four events. The 1C make has shift=1 and ascii 41. `shift_held` ends at 0.
- E0 75 then E0 F0 75: make ext=1 then break ext=1, code 75, ascii 00. Bytes AA and FA in between produce no event.
- 58, 58 (repeat), F0 58, then 1C: `caps_lock`=1 (toggled once) and the 1C event has caps=1, ascii 41.
- 17 make codes with no reads at DEPTH=16: `full`=1, `rx_wait`=0, 17th dropped, `overflow`=1. Push and pop in the same cycle while full leaves `count`=16. `ovf_clr` clears `overflow`.
- F0, then `TIMEOUT_CYCLES` idle, then 1C: make event, break=0. Separately, E0 followed by `rst`: `empty`=1 and state IDLE.
